// File: rtl/hdc_pkg.sv
// hdc_pkg: shared types and constants for the HDC counter-bank sequencers
package hdc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_e;
  localparam int COUNTER_LAT = 3;
  localparam int ITEM_W = 30;
endpackage

// File: rtl/hv_drain_timer.sv
// hv_drain_timer: loadable down-counter that flags its last counting cycle
module hv_drain_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] val_i,
  input  logic          en_i,
  output logic          term_o
);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end
  assign term_o = en_i && cnt_q == CW'(1);
endmodule

// File: rtl/hv_bundle_ctrl.sv
// hv_bundle_ctrl: sequences one majority-vote bundling run on the HDC counter bank
module hv_bundle_ctrl
  import hdc_pkg::*;
#(
  parameter int CORENUM = 2,
  parameter int DIM     = 32,
  parameter int W       = ITEM_W,
  parameter int LAT     = COUNTER_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [W-1:0]       item_num,
  input  logic [CORENUM-1:0] core_mask,
  input  logic               core_ready,
  output logic               busy,
  output logic               cnt_clr,
  output logic [CORENUM-1:0] store,
  output logic               store_flag,
  input  logic [DIM-1:0]     sign_bits,
  output logic [DIM-1:0]     out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               done,
  output logic               start_err
);
  localparam int CW = $clog2(LAT + 1);
  state_e             state_q;
  logic [W-1:0]       rem_q;
  logic [CORENUM-1:0] mask_q;
  logic [DIM-1:0]     out_data_q;
  logic               out_valid_q, done_q, start_err_q;
  logic               fire, drain_load, drain_term;
  assign fire       = rst && state_q == ACCUM && core_ready;
  assign store      = mask_q & {CORENUM{fire}};
  assign store_flag = |store;
  assign busy       = state_q != IDLE;
  assign cnt_clr    = !rst || state_q == IDLE;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;
  assign start_err  = start_err_q;
  // the drain window opens either from an empty run or from the last accepted item
  assign drain_load = (state_q == IDLE && start && item_num == '0) || (fire && rem_q == W'(1));
  hv_drain_timer #(.CW(CW)) u_drain (
    .clk    (clk),
    .rst    (rst),
    .load_i (drain_load),
    .val_i  (CW'(LAT)),
    .en_i   (state_q == DRAIN),
    .term_o (drain_term)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      mask_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      start_err_q <= start && state_q != IDLE;
      case (state_q)
        IDLE: if (start) begin
          rem_q   <= item_num;
          mask_q  <= core_mask;
          state_q <= item_num == '0 ? DRAIN : ACCUM;
        end
        ACCUM: if (fire) begin
          rem_q <= rem_q - 1'b1;
          if (rem_q == W'(1)) state_q <= DRAIN;
        end
        DRAIN: if (drain_term) begin
          out_data_q  <= sign_bits;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: if (out_valid_q && out_ready) begin
          out_valid_q <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hv_bundle_ctrl.sv
// tb_hv_bundle_ctrl: randomized bench with a counter-bank environment and a run-level reference model
module tb_hv_bundle_ctrl;
  localparam int CORENUM = 2, DIM = 32, W = 30, LAT = 3;
  logic clk = 0, rst = 0, start = 0, core_ready = 0, out_ready = 0;
  logic [W-1:0] item_num = '0;
  logic [CORENUM-1:0] core_mask = '0, store;
  logic busy, cnt_clr, store_flag, out_valid, done, start_err;
  logic [DIM-1:0] sign_bits, out_data;
  logic [DIM-1:0] cdata [CORENUM];
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;

  hv_bundle_ctrl #(.CORENUM(CORENUM), .DIM(DIM), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .item_num(item_num), .core_mask(core_mask),
    .core_ready(core_ready), .busy(busy), .cnt_clr(cnt_clr), .store(store),
    .store_flag(store_flag), .sign_bits(sign_bits), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .done(done), .start_err(start_err)
  );

  // counter bank stand-in: signed vote per dimension, sign visible LAT cycles after a strobe
  int env_acc [DIM];
  logic [DIM-1:0] sh [LAT];
  assign sign_bits = sh[LAT-1];
  initial begin
    for (int d = 0; d < DIM; d++) env_acc[d] = 0;
    for (int k = 0; k < LAT; k++) sh[k] = '0;
    forever begin
      logic [DIM-1:0] s;
      @(posedge clk);
      for (int d = 0; d < DIM; d++) begin
        if (cnt_clr === 1'b1) env_acc[d] = 0;
        else for (int c = 0; c < CORENUM; c++) if (store[c] === 1'b1) env_acc[d] += cdata[c][d] ? 1 : -1;
        s[d] = env_acc[d] < 0;
      end
      for (int k = LAT - 1; k > 0; k--) sh[k] <= sh[k-1];
      sh[0] <= s;
    end
  end

  // reference model: items outstanding, drain cycles left, result held for the consumer
  int m_items = 0, m_drain = 0;
  bit m_hold = 0, m_done = 0, m_err = 0;
  logic [CORENUM-1:0] m_mask = '0;
  logic [DIM-1:0] m_data = '0;
  int m_acc [DIM];
  function automatic bit m_idle();
    return m_items == 0 && m_drain == 0 && !m_hold;
  endfunction
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_items = 0; m_drain = 0; m_hold = 0; m_done = 0; m_err = 0; m_data = '0;
    end else begin
      m_err  = start && !m_idle();
      m_done = m_hold && out_ready;
      if (m_idle()) begin
        if (start) begin
          m_items = int'(item_num);
          m_mask  = core_mask;
          foreach (m_acc[d]) m_acc[d] = 0;
          if (item_num == '0) m_drain = LAT;
        end
      end else if (m_items > 0) begin
        if (core_ready) begin
          foreach (m_acc[d]) for (int c = 0; c < CORENUM; c++) if (m_mask[c]) m_acc[d] += cdata[c][d] ? 1 : -1;
          m_items--;
          if (m_items == 0) m_drain = LAT;
        end
      end else if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) begin
          m_hold = 1;
          foreach (m_acc[d]) m_data[d] = m_acc[d] < 0;
        end
      end else if (out_ready) m_hold = 0;
    end
  end

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    logic [CORENUM-1:0] es;
    @(negedge clk);
    if (chk_en) begin
      es = (rst && m_items > 0 && core_ready) ? m_mask : '0;
      cmp("busy", busy, !m_idle());
      cmp("cnt_clr", cnt_clr, !rst || m_idle());
      cmp("store", store, es);
      cmp("store_flag", store_flag, |es);
      cmp("out_valid", out_valid, m_hold);
      cmp("out_data", out_data, m_data);
      cmp("done", done, m_done);
      cmp("start_err", start_err, m_err);
    end
  end

  // rmode: 0 always ready, 1 fixed pattern, 2 random with stray starts; dmode: 0 random, 1 zeros, 2 two ones then zeros
  task automatic run(input int n, input logic [CORENUM-1:0] m, input int dmode, input logic [6:0] pat,
                     input int rmode, input int stall, input bit err_pulse,
                     output int lat, output logic [DIM-1:0] got);
    item_num = W'(n); core_mask = m; start = 1;
    @(posedge clk); #1 start = 0; lat = 0;
    for (int k = 0; ; k++) begin
      core_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (k < 7 ? pat[k] : 1'b1) : ($urandom_range(0, 9) < 6);
      for (int c = 0; c < CORENUM; c++) cdata[c] = dmode == 1 ? '0 : dmode == 2 ? (k < 2 ? '1 : '0) : DIM'($urandom);
      if (rmode == 2) start = $urandom_range(0, 7) == 0;
      if (out_valid === 1'b1) break;
      if (k > 300) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout: out_valid still low after %0d cycles", k);
        break;
      end
      @(posedge clk); #1 lat++;
    end
    got = out_data; start = 0;
    for (int s = 0; s < stall; s++) begin
      start = err_pulse && s == 4;
      @(posedge clk); #1;
    end
    start = 0;
    if (stall > 0) begin
      cmp("hold_valid", out_valid, 1);
      cmp("hold_data", out_data, got);
    end
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0; core_ready = 0;
    cmp("done_pulse", done, 1);
    cmp("idle_after", busy, 0);
  endtask

  initial begin
    int lat;
    logic [DIM-1:0] got;
    for (int c = 0; c < CORENUM; c++) cdata[c] = '0;
    rst = 0; start = 1; core_ready = 1; item_num = 3; core_mask = 2'b11;
    @(posedge clk); #1 chk_en = 1;
    repeat (4) @(posedge clk);
    #1;
    cmp("rst_cnt_clr", cnt_clr, 1);
    cmp("rst_busy", busy, 0);
    cmp("rst_store", store, 0);
    cmp("rst_valid", out_valid, 0);
    cmp("rst_data", out_data, 0);
    start = 0; core_ready = 0; rst = 1;
    @(posedge clk); #1;

    run(3, 2'b11, 2, 7'b0, 0, 0, 0, lat, got);
    cmp("basic_latency", lat + 1, 7);
    cmp("basic_data", got, 32'h0);
    run(4, 2'b01, 0, 7'b1011001, 1, 0, 0, lat, got);
    cmp("gap_latency", lat, 10);
    run(5, 2'b11, 1, 7'b0, 0, 0, 0, lat, got);
    cmp("neg_latency", lat + 1, 9);
    cmp("neg_data", got, 32'hFFFF_FFFF);
    run(3, 2'b11, 0, 7'b0, 0, 10, 1, lat, got);
    run(0, 2'b11, 0, 7'b0, 0, 0, 0, lat, got);
    cmp("zero_latency", lat + 1, 4);
    cmp("zero_data", got, 32'h0);

    item_num = 5; core_mask = 2'b11; start = 1;
    @(posedge clk); #1 start = 0; core_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    #1 cmp("abort_store", store, 0);
    @(posedge clk); #1;
    cmp("abort_cnt_clr", cnt_clr, 1);
    cmp("abort_busy", busy, 0);
    rst = 1; core_ready = 0;
    @(posedge clk); #1;
    cmp("abort_done", done, 0);

    repeat (25) run($urandom_range(0, 12), CORENUM'($urandom), 0, 7'b0, 2, $urandom_range(0, 6),
                    1'($urandom_range(0, 1)), lat, got);
    repeat (3) @(posedge clk);
    #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hv_bundle_ctrl.md
Name: hv_bundle_ctrl

Overview:
- Sequencer for one bundling (majority-vote) operation on the HDC counter bank.
- Clears the DIM counter instances, then issues one store strobe per accepted item to the enabled cores.
- After the last item it waits out the counter pipeline latency, captures the sign bits as the bundled hypervector word, and returns it through a valid/ready output handshake.
- Sits between the HDC core array and the counter bank in the HDC processor.

Parameters:
- CORENUM, 2, number of cores feeding each counter; width of store and core_mask.
- DIM, 32, number of counter instances (hypervector dimensions handled in parallel); width of sign_bits and out_data.
- W, 30, width of item_num; equals the counter accumulator width.
- LAT, 3, cycles from a store strobe until the counter sign bit reflects it.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  request a bundling run; sampled in IDLE only
- item_num  in  W  number of items to bundle; latched on accepted start
- core_mask  in  CORENUM  per-core store enable; latched on accepted start
- core_ready  in  1  cores present a valid result bit for the current item
- busy  out  1  high in every state except IDLE
- cnt_clr  out  1  active-high synchronous clear to the counter bank
- store  out  CORENUM  per-core store strobe
- store_flag  out  1  OR of store
- sign_bits  in  DIM  sign_bit outputs of the counter bank
- out_data  out  DIM  captured bundled hypervector word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- done  out  1  one-cycle pulse when out_data is accepted
- start_err  out  1  one-cycle pulse when start is asserted while busy

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE.
  - cnt_clr=1; busy, out_valid, done and start_err = 0; out_data=0; internal remaining and drain counters = 0.
  - store and store_flag read 0 combinationally while rst is low.
  - Reset mid-run abandons the run with no done pulse.
- States: IDLE, ACCUM, DRAIN, OUT.
- IDLE:
  - cnt_clr=1.
  - start=1 latches item_num into rem and core_mask into mask.
  - Next state is ACCUM if item_num!=0, else DRAIN with the drain counter loaded with LAT.
- ACCUM:
  - cnt_clr=0.
  - fire = core_ready (combinational).
  - store = mask & {CORENUM{fire}}; store_flag = |store.
  - Each fire decrements rem. Back-to-back fires every cycle are legal.
  - A fire with rem==1 moves to DRAIN with drain counter = LAT.
  - mask==0 still counts items but strobes nothing.
- DRAIN:
  - store=0, cnt_clr=0.
  - The counter decrements each cycle.
  - At the edge where the counter is 1: out_data <= sign_bits, out_valid <= 1, next state OUT.
  - DRAIN lasts exactly LAT cycles.
- OUT:
  - out_data is held stable while out_valid=1.
  - out_valid&out_ready at an edge: out_valid <= 0, done <= 1 for one cycle, next state IDLE.
  - Unbounded stall on out_ready is allowed.
- item_num==0: no strobes; out_data equals the cleared-counter sign bits, i.e. all 0.
- Tie votes (accumulator==0) yield bit 0. This is a counter property and is not corrected here.
- start while busy: ignored; start_err pulses on the following cycle; the current run is unaffected.
- rem never wraps; the ACCUM exit at rem==1 guarantees it.
- core_ready outside ACCUM is ignored.
- Latency from the accepted start edge to out_valid=1 with core_ready held high: item_num + LAT + 1 cycles. The +1 is the cycle from the out_valid register update to visibility.

Decomposition:
- Shared package hdc_pkg holds:
  - typedef of the state enum (IDLE, ACCUM, DRAIN, OUT);
  - localparam COUNTER_LAT=3, referenced as the LAT default;
  - item count width constant W=30, shared with the counter.
- Sub-module hv_drain_timer: a loadable down-counter with a terminal pulse. It is natural for reuse by other HDC sequencers. Otherwise the block is flat.

Test Plan:
- Reset: hold rst=0 5 cycles with start=1 and core_ready=1 -> cnt_clr=1, busy=0, store=0, out_valid=0, out_data=0.
- Basic run: start with item_num=3, core_mask=2'b11, core_ready=1 -> store=2'b11 for exactly 3 consecutive cycles. Counter model with results +1,+1,-1 per core yields sign 0 for its DIM bit; out_valid rises LAT+1 cycles after the last strobe; out_ready=1 gives done pulse, then IDLE.
- Gaps and mask: item_num=4, core_mask=2'b01, core_ready pattern 1,0,0,1,1,0,1 -> store=2'b01 exactly on the 4 ready cycles, store[1] never high; DRAIN starts after the 7th cycle.
- Negative majority: all cores drive 0 for item_num=5 -> all counters at -10 -> out_data=all ones (for DIM=32, 0xFFFFFFFF).
- Backpressure and start_err: out_ready=0 for 10 cycles, with start pulsed at cycle 4 -> out_data stable, out_valid held, start_err pulses once, no new run; out_ready=1 then gives a single done pulse.
- Zero and abort: item_num=0 -> no strobes, out_valid after LAT+1 cycles, out_data=0. Separately, rst=0 mid-ACCUM with rem=2 -> IDLE next cycle, no done, cnt_clr=1.
